// File: rtl/gcd_ci_pkg.sv
// Shared types for the binary-GCD custom instruction: CI mode field and FSM states.
package gcd_ci_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_GCD      = 2'd0,
        MODE_COPRIME  = 2'd1,
        MODE_LAST_RES = 2'd2,
        MODE_LAST_CYC = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STRIP,
        ST_REDUCE,
        ST_FINISH
    } state_e;

    // Read-back modes skip the datapath and answer from the status registers.
    function automatic logic is_readback(input mode_e m);
        return (m == MODE_LAST_RES) || (m == MODE_LAST_CYC);
    endfunction

endpackage

// File: rtl/gcd_stein_core.sv
// Stein GCD engine: strips shared factors of two, then reduces one step per
// enabled cycle. Also counts enabled cycles from the accepted start to FINISH.
module gcd_stein_core
    import gcd_ci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             i_go,
    input  logic             i_skip,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_fin,
    output logic             o_to_fin,
    output logic [WIDTH-1:0] o_gcd,
    output logic [CNT_W-1:0] o_cyc_nxt
);

    localparam int K_W = $clog2(WIDTH + 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] w_cyc_inc;

    // Saturating increment of the per-operation cycle counter.
    assign w_cyc_inc = (&r_cyc) ? r_cyc : r_cyc + 1'b1;

    assign o_busy    = (r_state != ST_IDLE);
    assign o_fin     = (r_state == ST_FINISH);
    assign o_to_fin  = (r_state == ST_REDUCE) && (r_b == '0);
    // Shared power of two restored; the true GCD always fits in WIDTH bits.
    assign o_gcd     = r_a << r_k;
    assign o_cyc_nxt = w_cyc_inc;

    // FSM and datapath; nothing moves while clk_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_cyc   <= '0;
        end else if (clk_en) begin
            // NOTE: non-blocking assignments so every branch reads pre-edge a/b/k.
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_k     <= '0;
                        r_cyc   <= '0;
                        r_state <= i_skip ? ST_FINISH : ST_STRIP;
                    end
                end
                ST_STRIP: begin
                    r_cyc <= w_cyc_inc;
                    if (r_a == '0 || r_b == '0) begin
                        r_a     <= r_a | r_b;
                        r_b     <= '0;
                        r_state <= ST_REDUCE;
                    end else if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    r_cyc <= w_cyc_inc;
                    if (r_b == '0) begin
                        r_state <= ST_FINISH;
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        r_a <= (r_a - r_b) >> 1;
                    end else if (r_b > r_a) begin
                        r_b <= (r_b - r_a) >> 1;
                    end else begin
                        r_b <= '0;
                    end
                end
                ST_FINISH: begin
                    r_cyc   <= w_cyc_inc;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gcd_stein_ci.sv
// Nios II multi-cycle custom instruction: Stein GCD, coprime test and status
// read-backs selected by the n field. done is high for the FINISH cycle.
module gcd_stein_ci
    import gcd_ci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [WIDTH-1:0]  dataa,
    input  logic [WIDTH-1:0]  datab,
    input  logic [MODE_W-1:0] n,
    output logic              done,
    output logic [WIDTH-1:0]  result
);

    mode_e            w_mode_in;
    logic             w_busy;
    logic             w_fin;
    logic             w_to_fin;
    logic             w_accept;
    logic [WIDTH-1:0] w_gcd;
    logic [CNT_W-1:0] w_cyc_nxt;

    mode_e            r_mode;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_last_res;
    logic [CNT_W-1:0] r_last_cyc;

    assign w_mode_in = mode_e'(n);
    assign w_accept  = start && !w_busy;

    gcd_stein_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .i_go      (start),
        .i_skip    (is_readback(w_mode_in)),
        .i_a       (dataa),
        .i_b       (datab),
        .o_busy    (w_busy),
        .o_fin     (w_fin),
        .o_to_fin  (w_to_fin),
        .o_gcd     (w_gcd),
        .o_cyc_nxt (w_cyc_nxt)
    );

    // Mode latch, result/done registers and last-operation status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= MODE_GCD;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_last_res <= '0;
            r_last_cyc <= '0;
        end else if (clk_en) begin
            if (w_accept) begin
                r_mode <= w_mode_in;
                if (w_mode_in == MODE_LAST_RES) begin
                    r_result <= r_last_res;
                    r_done   <= 1'b1;
                end else if (w_mode_in == MODE_LAST_CYC) begin
                    r_result <= WIDTH'(r_last_cyc);
                    r_done   <= 1'b1;
                end
            end else if (w_to_fin) begin
                r_done     <= 1'b1;
                r_last_res <= w_gcd;
                if (r_mode == MODE_COPRIME) begin
                    r_result <= (w_gcd == WIDTH'(1)) ? WIDTH'(1) : '0;
                end else begin
                    r_result <= w_gcd;
                end
            end else if (w_fin) begin
                r_done <= 1'b0;
                // The count includes the FINISH cycle itself.
                if (!is_readback(r_mode)) begin
                    r_last_cyc <= w_cyc_nxt;
                end
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_gcd_stein_ci.sv
// Bench for gcd_stein_ci at WIDTH=32 and WIDTH=8. Expected results come from
// Euclid's algorithm; expected cycle counts from stepping Stein's rules.
// done is high in the FINISH cycle; latency = enabled edges from the start
// edge (inclusive) up to the edge that raises done.
module tb_gcd_stein_ci;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32;
    logic        start8;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [1:0]  n;
    logic        en_rand = 1'b0;
    logic        rand_bit = 1'b1;
    logic        clk_en;
    logic        done32;
    logic        done8;
    logic [31:0] res32;
    logic [7:0]  res8;

    int          n_vec = 0;
    int          n_err = 0;
    int          nissued[2];
    int          ndone[2];
    int          lat[2];
    int          exp_lat[2];
    logic [63:0] exp_res[2];
    logic [63:0] last_res_m[2];
    logic [63:0] last_cyc_m[2];

    always #5 clk = ~clk;

    assign clk_en = en_rand ? rand_bit : 1'b1;

    always @(posedge clk) begin
        #1 rand_bit = 1'($urandom_range(0, 1));
    end

    gcd_stein_ci #(.WIDTH(32), .CNT_W(16)) u32 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start32),
        .dataa(dataa), .datab(datab), .n(n), .done(done32), .result(res32)
    );

    gcd_stein_ci #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start8),
        .dataa(dataa[7:0]), .datab(datab[7:0]), .n(n), .done(done8), .result(res8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] gcd_m(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Enabled cycles spent in STRIP, REDUCE and FINISH for one operation.
    function automatic int stein_cyc(input logic [63:0] a, input logic [63:0] b);
        int c = 0;
        if (a == 0 || b == 0) begin
            a = a | b;
            b = 0;
            c = 1;
        end else begin
            while (!a[0] && !b[0]) begin
                a = a >> 1;
                b = b >> 1;
                c++;
            end
            c++;
        end
        while (b != 0) begin
            if (!a[0])      a = a >> 1;
            else if (!b[0]) b = b >> 1;
            else if (a > b) a = (a - b) >> 1;
            else if (b > a) b = (b - a) >> 1;
            else            b = 0;
            c++;
        end
        return c + 2;
    endfunction

    // Done/result/latency checks for one DUT, sampled on the falling edge.
    task automatic mon(input int s, input logic d, input logic [63:0] r);
        int w = (s != 0) ? 8 : 32;
        if (d === 1'b1 && clk_en === 1'b1) begin
            if (nissued[s] == ndone[s]) begin
                check($sformatf("spurious_done_w%0d", w), {63'b0, d}, 64'd0);
            end else begin
                check($sformatf("result_w%0d", w), r, exp_res[s]);
                check($sformatf("latency_w%0d", w), lat[s], exp_lat[s]);
                check($sformatf("latency_bound_w%0d", w), {63'b0, lat[s] <= 2 * w + 3}, 64'd1);
                ndone[s]++;
            end
        end
    endtask

    // Single compare process for both instances.
    always begin
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (nissued[s] == ndone[s]) lat[s] = 0;
            else if (clk_en === 1'b1)   lat[s]++;
        end
        @(negedge clk);
        mon(0, done32, {32'b0, res32});
        mon(1, done8, {56'b0, res8});
    end

    task automatic op_begin(input int s, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] m, input longint lit_res, input int lit_cyc);
        int          w = (s != 0) ? 8 : 32;
        logic [63:0] mask = (64'd1 << w) - 1;
        logic [63:0] g;
        a = a & mask;
        b = b & mask;
        if (m < 2) begin
            g          = gcd_m(a, b);
            exp_res[s] = (m == 0) ? g : {63'b0, g == 1};
            exp_lat[s] = stein_cyc(a, b);
            last_res_m[s] = g;
            last_cyc_m[s] = 64'(exp_lat[s]);
        end else if (m == 2) begin
            exp_res[s] = last_res_m[s];
            exp_lat[s] = 1;
        end else begin
            exp_res[s] = last_cyc_m[s] & mask;
            exp_lat[s] = 1;
        end
        if (lit_res >= 0) check("model_result_pin", exp_res[s], 64'(lit_res));
        if (lit_cyc >= 0) check("model_cycles_pin", 64'(exp_lat[s]), 64'(lit_cyc));
        dataa = a[31:0];
        datab = b[31:0];
        n     = m;
        nissued[s]++;
        if (s != 0) start8 = 1'b1;
        else        start32 = 1'b1;
        do @(posedge clk); while (clk_en !== 1'b1);
        #1;
        start32 = 1'b0;
        start8  = 1'b0;
        dataa   = $urandom;
        datab   = $urandom;
        n       = 2'($urandom_range(0, 3));
    endtask

    task automatic op_wait(input int s);
        for (int t = 0; t < 2000 && ndone[s] != nissued[s]; t++) begin
            @(negedge clk);
            #1;
        end
        if (ndone[s] != nissued[s]) begin
            check("done_timeout", 64'(ndone[s]), 64'(nissued[s]));
            nissued[s] = ndone[s];
        end
    endtask

    task automatic op(input int s, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] m, input longint lit_res, input int lit_cyc);
        op_begin(s, a, b, m, lit_res, lit_cyc);
        op_wait(s);
        do @(posedge clk); while (clk_en !== 1'b1);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            nissued[s] = 0; ndone[s] = 0; lat[s] = 0; exp_lat[s] = 0;
            exp_res[s] = 0; last_res_m[s] = 0; last_cyc_m[s] = 0;
        end
        reset = 1'b0; start32 = 1'b0; start8 = 1'b0;
        dataa = '0; datab = '0; n = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_done_w32",   {63'b0, done32}, 64'd0);
        check("reset_result_w32", {32'b0, res32},  64'd0);
        check("reset_done_w8",    {63'b0, done8},  64'd0);
        check("reset_result_w8",  {56'b0, res8},   64'd0);
        @(posedge clk); #1;
        op(0, 0, 0, 2, 0, 1);
        op(0, 0, 0, 3, 0, 1);

        // T1: plain GCD
        op(0, 2147483647, 524287, 0, 1, -1);
        op(0, 91, 21, 0, 7, 7);
        op(0, 1000000000, 1, 0, 1, -1);
        op(0, 48, 180, 0, 12, 11);
        // T2: zero operands
        op(0, 0, 0, 0, 0, 3);
        op(0, 0, 12, 0, 12, 3);
        op(0, 12, 0, 0, 12, 3);
        // T3: coprime test and read-backs
        op(0, 2, 1023, 1, 1, -1);
        op(0, 91, 21, 1, 0, 7);
        op(0, 0, 0, 2, 7, 1);
        op(0, 0, 0, 3, 7, 1);
        // Narrow instance directed vectors
        op(1, 48, 180, 0, 12, 11);
        op(1, 91, 21, 1, 0, 7);
        op(1, 0, 0, 2, 7, 1);
        op(1, 0, 0, 3, 7, 1);
        op(1, 255, 0, 0, 255, -1);

        // T4: gated clock enable must not change result or cycle count
        en_rand = 1'b1;
        op(0, 91, 21, 0, 7, 7);
        en_rand = 1'b0;
        op(0, 0, 0, 3, 7, 1);

        // T5a: start re-pulsed mid-operation is ignored
        op_begin(0, 91, 21, 0, 7, 7);
        repeat (2) @(posedge clk);
        #1 dataa = 5; datab = 10; n = 2'd0; start32 = 1'b1;
        repeat (2) @(posedge clk);
        #1 start32 = 1'b0;
        op_wait(0);
        // T5b: start raised only during the FINISH cycle is ignored
        dataa = 5; datab = 10; n = 2'd0; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (10) @(negedge clk);
        check("finish_start_ignored", {63'b0, done32}, 64'd0);
        @(posedge clk); #1;
        op(0, 0, 0, 2, 7, 1);

        // T5c: reset mid-operation
        op_begin(0, 2147483647, 524287, 0, 1, -1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        nissued[0] = ndone[0];
        for (int s = 0; s < 2; s++) begin
            last_res_m[s] = 0;
            last_cyc_m[s] = 0;
        end
        repeat (3) @(negedge clk);
        check("midop_reset_done",   {63'b0, done32}, 64'd0);
        check("midop_reset_result", {32'b0, res32},  64'd0);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        check("after_reset_no_done", {63'b0, done32}, 64'd0);
        @(posedge clk); #1;
        op(0, 0, 0, 2, 0, 1);
        op(0, 0, 0, 3, 0, 1);
        op(1, 0, 0, 2, 0, 1);

        // T6: random pairs with power-of-two, equal and zero patterns
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < ((s != 0) ? 1500 : 500); i++) begin
                logic [63:0] ra;
                logic [63:0] rb;
                logic [1:0]  rm;
                int          w;
                int          p;
                int          r;
                w = (s != 0) ? 8 : 32;
                case ($urandom_range(0, 5))
                    0: begin ra = 64'($urandom); rb = 64'($urandom); end
                    1: begin
                        ra = 64'd1 << $urandom_range(0, w - 1);
                        rb = 64'd1 << $urandom_range(0, w - 1);
                    end
                    2: begin ra = 64'($urandom); rb = ra; end
                    3: begin
                        ra = 64'($urandom); rb = 64'($urandom);
                        if ($urandom_range(0, 1) != 0) ra = 0;
                        else                            rb = 0;
                    end
                    4: begin
                        r  = $urandom_range(0, w - 1);
                        ra = 64'($urandom) << r;
                        rb = 64'($urandom) << r;
                    end
                    default: begin
                        ra = 64'($urandom_range(0, 300));
                        rb = 64'($urandom_range(0, 300));
                    end
                endcase
                p  = $urandom_range(0, 9);
                rm = (p < 5) ? 2'd0 : (p < 8) ? 2'd1 : (p == 8) ? 2'd2 : 2'd3;
                op(s, ra, rb, rm, -1, -1);
            end
        end

        check("done_count_w32", 64'(ndone[0]), 64'(nissued[0]));
        check("done_count_w8",  64'(ndone[1]), 64'(nissued[1]));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
